banked_vram: RTL
================

BANKED_VRAM -- requirements
Module: banked_vram

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 2, meaning VRAM bank count (power of two, 2..8).
REQ-002 SHALL have parameter ADDR_W, default 13, meaning byte address width per bank (8 KB at default).
REQ-003 SHALL have parameter WBUF_DEPTH, default 4, meaning posted-write buffer entries (power of two, >=2).
REQ-004 SHALL have port: clk  in  1  system clock; all logic on rising edge.
REQ-005 SHALL have port: reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port: cpu_en  in  1  CPU clock enable qualifying bank-register writes.
REQ-007 SHALL have port: cgb  in  1  colour mode; bank switching allowed only when high.
REQ-008 SHALL have port: addr  in  ADDR_W  CPU byte address.
REQ-009 SHALL have port: wdata  in  8  CPU write data / bank-select value.
REQ-010 SHALL have port: write  in  1  CPU write level; its rising edge is one write strobe.
REQ-011 SHALL have port: rdata  out  8  CPU read data from the selected bank.
REQ-012 SHALL have port: switch_bank  in  1  bank-register write select.
REQ-013 SHALL have port: bank_rdata  out  8  bank-register readback: upper bits 1, low clog2(NUM_BANKS) bits = bank.
REQ-014 SHALL have port: lock  in  1  PPU owns VRAM (mode 3); CPU access blocked.
REQ-015 SHALL have port: ppu_addr  in  ADDR_W  PPU fetch address.
REQ-016 SHALL have port: ppu_rdata  out  8*NUM_BANKS  all banks at ppu_addr; bank k in bits [8k+7:8k].
REQ-017 SHALL have port: wbuf_full  out  1  posted-write buffer full.

Function
REQ-018 SHALL update bank <= wdata[clog2(NUM_BANKS)-1:0] on a clock with cpu_en & switch_bank & cgb; otherwise hold.
REQ-019 SHALL register write every clock; strobe = write & ~write_prev; exactly one memory write per strobe, none while write stays high.
REQ-020 SHALL, when busy = 0 (busy = lock or buffer non-empty), commit a strobe to bank `bank` at addr on that edge.
REQ-021 SHALL deliver rdata one clock after addr from bank `bank`, and SHALL return 8'hFF for reads whose address cycle had busy = 1.
REQ-022 SHALL deliver ppu_rdata one clock after ppu_addr for every bank, independent of lock and bank.
REQ-023 SHALL give read-first semantics: PPU or CPU read of an address written the same edge returns the old value.
REQ-024 SHALL, when busy = 1, push a strobe as {bank, addr, wdata} to the buffer tail; strobes while full are dropped.
REQ-025 SHALL, when lock = 0 and buffer non-empty, pop one entry per clock in FIFO order and write it to its captured bank/address.
REQ-026 SHALL accept a push in the same clock as a pop even when full; occupancy unchanged.
REQ-027 SHALL keep buffered entries bound to their captured bank; bank switches after capture have no effect on them.
REQ-028 SHALL freeze draining on the clock lock rises; remaining entries resume when lock falls.
REQ-029 SHALL drive wbuf_full combinationally from occupancy = WBUF_DEPTH.

Reset
REQ-030 SHALL, on reset_n low, asynchronously clear bank, write_prev, buffer pointers/occupancy, rdata (8'hFF), wbuf_full (0); memory contents are not cleared.
REQ-031 SHALL discard all pending buffered writes on reset, including mid-drain; no partial memory write after reset asserts.

Configuration
REQ-032 SHALL compile the posted-write buffer only when VRAM_WBUF_EN is defined.
REQ-033 SHALL, without VRAM_WBUF_EN, drop strobes with lock = 1, define busy = lock, tie wbuf_full to 0, and ignore WBUF_DEPTH.

Structure
REQ-034 SHALL place the buffer entry struct {bank, addr, data} and an 8'hFF open-bus constant in package vram_pkg.
REQ-035 SHALL instantiate NUM_BANKS copies of sub-module vram_bank_ram (1 read/write port, 1-cycle read, write enable) via generate.

Verification
REQ-036 SHALL cover: cgb = 1, write 8'h01 to bank register, write 8'hAB @0x0010 -> bank1 = AB, bank0 unchanged, bank_rdata = 8'hFF.
REQ-037 SHALL cover: cgb = 0, write 8'h01 to bank register -> bank stays 0, bank_rdata = 8'hFE.
REQ-038 SHALL cover: write held high 5 clocks with data 8'h5A -> exactly one memory write.
REQ-039 SHALL cover (macro on): lock = 1, 5 strobes to 0x0100..0x0104 with DEPTH 4 -> wbuf_full = 1, fifth dropped, CPU read = 8'hFF; lock = 0 -> four writes in order on four clocks.
REQ-040 SHALL cover (macro off): lock = 1, strobe 8'h77 @0x0200 -> memory unchanged, wbuf_full = 0.
REQ-041 SHALL cover: reset_n pulsed low after two of four drain writes -> remaining two lost, occupancy 0, rdata = 8'hFF.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared types and constants for the banked VRAM: posted-write entry layout
// and the open-bus read value.
package vram_pkg;

    localparam int VRAM_MAX_BANK_W = 3;
    localparam int VRAM_MAX_ADDR_W = 16;

    localparam logic [7:0] OPEN_BUS = 8'hFF;

    // Entry fields are sized for the largest legal configuration.
    typedef struct packed {
        logic [VRAM_MAX_BANK_W-1:0] bank;
        logic [VRAM_MAX_ADDR_W-1:0] addr;
        logic [7:0]                 data;
    } wbuf_entry_t;

endpackage

// File: rtl/vram_bank_ram.sv
// One VRAM bank: a read/write port for the CPU/drain path and a read-only
// port for the PPU, both with one-cycle read-first behaviour.
module vram_bank_ram #(
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] i_rw_addr,
    input  logic              i_rw_we,
    input  logic [7:0]        i_rw_wdata,
    output logic [7:0]        o_rw_rdata,
    input  logic [ADDR_W-1:0] i_ro_addr,
    output logic [7:0]        o_ro_rdata
);

    logic [7:0] r_mem [2**ADDR_W];
    logic [7:0] r_rw_rdata;
    logic [7:0] r_ro_rdata;

    // Storage array; both reads see the contents from before this edge.
    always_ff @(posedge clk) begin
        if (i_rw_we) begin
            r_mem[i_rw_addr] <= i_rw_wdata;
        end
        r_rw_rdata <= r_mem[i_rw_addr];
        r_ro_rdata <= r_mem[i_ro_addr];
    end

    assign o_rw_rdata = r_rw_rdata;
    assign o_ro_rdata = r_ro_rdata;

endmodule

// File: rtl/banked_vram.sv
// Banked VRAM with CPU bank register, PPU lock arbitration and an optional
// posted-write buffer enabled by defining VRAM_WBUF_EN.
module banked_vram
    import vram_pkg::*;
#(
    parameter int NUM_BANKS  = 2,
    parameter int ADDR_W     = 13,
    parameter int WBUF_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cpu_en,
    input  logic                   cgb,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [7:0]             wdata,
    input  logic                   write,
    output logic [7:0]             rdata,
    input  logic                   switch_bank,
    output logic [7:0]             bank_rdata,
    input  logic                   lock,
    input  logic [ADDR_W-1:0]      ppu_addr,
    output logic [8*NUM_BANKS-1:0] ppu_rdata,
    output logic                   wbuf_full
);

    localparam int BANK_W = $clog2(NUM_BANKS);

    logic [BANK_W-1:0]    r_bank;
    logic                 r_write_prev;
    logic                 r_rd_valid;
    logic [BANK_W-1:0]    r_rd_bank;

    logic                 w_strobe;
    logic                 w_busy;
    logic                 w_wr_en;
    logic [BANK_W-1:0]    w_wr_bank;
    logic [ADDR_W-1:0]    w_wr_addr;
    logic [7:0]           w_wr_data;
    logic [NUM_BANKS-1:0] w_bank_we;
    logic [7:0]           w_bank_rdata [NUM_BANKS];

    assign w_strobe   = write & ~r_write_prev;
    assign bank_rdata = {{(8-BANK_W){1'b1}}, r_bank};

    // Bank register and write-level history for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bank       <= '0;
            r_write_prev <= 1'b0;
        end else begin
            r_write_prev <= write;
            if (cpu_en && switch_bank && cgb) begin
                r_bank <= wdata[BANK_W-1:0];
            end else begin
                r_bank <= r_bank;
            end
        end
    end

`ifdef VRAM_WBUF_EN
    localparam int PTR_W = $clog2(WBUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wbuf_entry_t       r_buf [WBUF_DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    wbuf_entry_t       w_head;
    wbuf_entry_t       w_new;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(WBUF_DEPTH));
    assign w_busy  = lock | ~w_empty;
    // Draining stops on any edge that sees lock high.
    assign w_pop   = ~lock & ~w_empty;
    assign w_push  = w_strobe & w_busy & (~w_full | w_pop);
    assign w_head  = r_buf[r_head];
    assign w_new   = '{bank: VRAM_MAX_BANK_W'(r_bank),
                       addr: VRAM_MAX_ADDR_W'(addr),
                       data: wdata};
    assign wbuf_full = w_full;

    // Entry storage; slots are only read after being written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf[r_tail] <= w_new;
        end
    end

    // FIFO pointers and occupancy; reset discards every pending entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end else begin
                r_tail <= r_tail;
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end else begin
                r_head <= r_head;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Single write path per bank: a drain has priority, a direct commit
    // can only happen when the buffer is empty anyway.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_bank = r_bank;
        w_wr_addr = addr;
        w_wr_data = wdata;
        if (w_pop) begin
            w_wr_en   = 1'b1;
            w_wr_bank = w_head.bank[BANK_W-1:0];
            w_wr_addr = w_head.addr[ADDR_W-1:0];
            w_wr_data = w_head.data;
        end else begin
            w_wr_en   = w_strobe & ~w_busy;
        end
    end
`else
    assign w_busy    = lock;
    // A legal depth is never zero, so this is constant 0.
    assign wbuf_full = (WBUF_DEPTH == 0) ? 1'b1 : 1'b0;

    // Direct commit path; strobes during lock are dropped.
    always_comb begin
        w_wr_bank = r_bank;
        w_wr_addr = addr;
        w_wr_data = wdata;
        w_wr_en   = w_strobe & ~w_busy;
    end
`endif

    // Remember whether this address cycle was allowed to read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_valid <= 1'b0;
            r_rd_bank  <= '0;
        end else begin
            r_rd_valid <= ~w_busy;
            r_rd_bank  <= r_bank;
        end
    end

    assign rdata = r_rd_valid ? w_bank_rdata[r_rd_bank] : OPEN_BUS;

    for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
        assign w_bank_we[k] = w_wr_en && (w_wr_bank == BANK_W'(k));

        vram_bank_ram #(
            .ADDR_W (ADDR_W)
        ) u_ram (
            .clk        (clk),
            .i_rw_addr  (w_wr_addr),
            .i_rw_we    (w_bank_we[k]),
            .i_rw_wdata (w_wr_data),
            .o_rw_rdata (w_bank_rdata[k]),
            .i_ro_addr  (ppu_addr),
            .o_ro_rdata (ppu_rdata[8*k +: 8])
        );
    end

endmodule
